// File: rtl/crc10_pkg.sv
// Shared types, constants and helpers for the crc10 framing controller and its lock tracker.
package crc10_pkg;

  localparam int CRC10_W   = 62;
  localparam int CRC10_LEN = 10;

  typedef enum logic [1:0] {
    HUNT,
    BODY,
    HOLD,
    CHECK
  } crc10_ctrl_st_e;

  typedef enum logic {
    UNLOCKED,
    LOCKED
  } crc10_lock_st_e;

  // Increment that sticks at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v == max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/crc10_lock_fsm.sv
// Frame-lock tracker: counts consecutive good frames to lock and consecutive bad frames to unlock.
module crc10_lock_fsm
  import crc10_pkg::*;
#(
  parameter int LOCK_GOOD_THR = 4,
  parameter int LOCK_ERR_THR  = 3
) (
  input  logic           clk_390p625M,
  input  logic           rst,
  input  logic           ok,
  input  logic           err,
  output logic           lock,
  output logic           realign_req,
  output crc10_lock_st_e dbg_state
);

  localparam int RUN_MAX = (LOCK_GOOD_THR > LOCK_ERR_THR) ? LOCK_GOOD_THR : LOCK_ERR_THR;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam logic [RUN_W-1:0] GOOD_LAST = RUN_W'(LOCK_GOOD_THR - 1);
  localparam logic [RUN_W-1:0] ERR_LAST  = RUN_W'(LOCK_ERR_THR - 1);

  crc10_lock_st_e   state_q, state_d;
  logic [RUN_W-1:0] good_run_q, good_run_d;
  logic [RUN_W-1:0] err_run_q, err_run_d;
  logic             realign_d;

  always_ff @(posedge clk_390p625M) begin
    if (rst) begin
      state_q     <= UNLOCKED;
      good_run_q  <= '0;
      err_run_q   <= '0;
      realign_req <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_run_q  <= good_run_d;
      err_run_q   <= err_run_d;
      realign_req <= realign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    good_run_d = good_run_q;
    err_run_d  = err_run_q;
    realign_d  = 1'b0;
    case (state_q)
      UNLOCKED: begin
        if (ok) begin
          if (good_run_q == GOOD_LAST) begin
            state_d    = LOCKED;
            good_run_d = '0;
            err_run_d  = '0;
          end else begin
            good_run_d = good_run_q + 1'b1;
          end
        end else if (err) begin
          good_run_d = '0;
        end
      end
      LOCKED: begin
        if (err) begin
          if (err_run_q == ERR_LAST) begin
            state_d    = UNLOCKED;
            realign_d  = 1'b1;
            good_run_d = '0;
            err_run_d  = '0;
          end else begin
            err_run_d = err_run_q + 1'b1;
          end
        end else if (ok) begin
          err_run_d = '0;
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  assign lock      = (state_q == LOCKED);
  assign dbg_state = state_q;

endmodule

// File: rtl/crc10_frame_ctrl.sv
// Frame sequencer in front of the crc10 checker: frames words, samples the verdict,
// keeps saturating statistics and drives the lock tracker.
module crc10_frame_ctrl
  import crc10_pkg::*;
#(
  parameter int FRAME_WORDS   = 32,
  parameter int LOCK_GOOD_THR = 4,
  parameter int LOCK_ERR_THR  = 3,
  parameter int CNT_W         = 22
) (
  input  logic               clk_390p625M,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               in_sof,
  input  logic [CRC10_W-1:0] in_data,
  output logic               crc10_en,
  output logic [CRC10_W-1:0] crc10_data_out,
  output logic               frame_tail_flag,
  input  logic               check_result,
  output logic               frame_ok,
  output logic               frame_err,
  output logic               lock,
  output logic               realign_req,
  output logic [CNT_W-1:0]   good_cnt,
  output logic [CNT_W-1:0]   abort_cnt,
  output logic [CNT_W-1:0]   drop_cnt,
  output crc10_ctrl_st_e     dbg_state,
  output crc10_lock_st_e     dbg_lock_state
);

  // Handshake: in_valid qualifies in_sof and in_data for one cycle; there is no ready,
  // the source is never stalled and a missing word inside a frame aborts it.

  localparam int IDX_W = $clog2(FRAME_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

  crc10_ctrl_st_e     state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               en_d, tail_d, ok_d, err_d, abort_d, drop_d;
  logic [CRC10_W-1:0] data_d;
  logic               sof_word;

  assign sof_word = in_valid & in_sof;

  always_ff @(posedge clk_390p625M) begin
    if (rst) begin
      state_q         <= HUNT;
      idx_q           <= '0;
      crc10_en        <= 1'b0;
      crc10_data_out  <= '0;
      frame_tail_flag <= 1'b0;
      frame_ok        <= 1'b0;
      frame_err       <= 1'b0;
      good_cnt        <= '0;
      abort_cnt       <= '0;
      drop_cnt        <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      crc10_en        <= en_d;
      crc10_data_out  <= data_d;
      frame_tail_flag <= tail_d;
      frame_ok        <= ok_d;
      frame_err       <= err_d;
      if (ok_d)    good_cnt  <= CNT_W'(sat_inc(32'(good_cnt), CNT_W));
      if (abort_d) abort_cnt <= CNT_W'(sat_inc(32'(abort_cnt), CNT_W));
      if (drop_d)  drop_cnt  <= CNT_W'(sat_inc(32'(drop_cnt), CNT_W));
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    en_d    = 1'b0;
    tail_d  = 1'b0;
    data_d  = crc10_data_out;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    abort_d = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      HUNT: begin
        if (sof_word) begin
          state_d = BODY;
          idx_d   = IDX_W'(1);
          en_d    = 1'b1;
          data_d  = in_data;
        end
      end
      BODY: begin
        if (!in_valid) begin
          // Dropping en for a cycle makes crc10 clear its LFSR.
          abort_d = 1'b1;
          state_d = HUNT;
          idx_d   = '0;
        end else if (in_sof) begin
          abort_d = 1'b1;
          idx_d   = IDX_W'(1);
          en_d    = 1'b1;
          data_d  = in_data;
        end else begin
          en_d   = 1'b1;
          data_d = in_data;
          if (idx_q == LAST_IDX) begin
            tail_d  = 1'b1;
            state_d = HOLD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      HOLD: begin
        drop_d  = sof_word;
        state_d = CHECK;
      end
      CHECK: begin
        drop_d  = sof_word;
        ok_d    = check_result;
        err_d   = ~check_result;
        state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase
  end

  assign dbg_state = state_q;

  // Fed with the next-cycle verdict so lock moves together with the frame_ok/frame_err pulse.
  crc10_lock_fsm #(
    .LOCK_GOOD_THR(LOCK_GOOD_THR),
    .LOCK_ERR_THR (LOCK_ERR_THR)
  ) u_lock (
    .clk_390p625M(clk_390p625M),
    .rst         (rst),
    .ok          (ok_d),
    .err         (err_d),
    .lock        (lock),
    .realign_req (realign_req),
    .dbg_state   (dbg_lock_state)
  );

endmodule
